// File: rtl/lfsr_pkg.sv
// Shared constants, types and the maximal-length tap table for the lfsr_gen family.
// Tap masks put bit i into the feedback XOR when set.
package lfsr_pkg;

  localparam int unsigned MIN_WIDTH = 4;
  localparam int unsigned MAX_WIDTH = 32;

  // Per-cycle update chosen by the top-level next-state logic.
  typedef enum logic [1:0] {
    ActIdle,
    ActLoad,
    ActStep
  } lfsr_act_e;

  // Primitive polynomials, one per width, expressed as Fibonacci tap masks.
  function automatic logic [MAX_WIDTH-1:0] max_taps(input int unsigned width);
    logic [MAX_WIDTH-1:0] taps;
    unique case (width)
      4:       taps = 32'h0000_000C;
      5:       taps = 32'h0000_0014;
      6:       taps = 32'h0000_0030;
      7:       taps = 32'h0000_0060;
      8:       taps = 32'h0000_00B8;
      9:       taps = 32'h0000_0110;
      10:      taps = 32'h0000_0240;
      11:      taps = 32'h0000_0500;
      12:      taps = 32'h0000_0829;
      13:      taps = 32'h0000_100D;
      14:      taps = 32'h0000_2015;
      15:      taps = 32'h0000_6000;
      16:      taps = 32'h0000_B400;
      17:      taps = 32'h0001_2000;
      18:      taps = 32'h0002_0400;
      19:      taps = 32'h0004_0023;
      20:      taps = 32'h0009_0000;
      21:      taps = 32'h0014_0000;
      22:      taps = 32'h0030_0000;
      23:      taps = 32'h0042_0000;
      24:      taps = 32'h00E1_0000;
      25:      taps = 32'h0120_0000;
      26:      taps = 32'h0200_0023;
      27:      taps = 32'h0400_0013;
      28:      taps = 32'h0900_0000;
      29:      taps = 32'h1400_0000;
      30:      taps = 32'h2000_0029;
      31:      taps = 32'h4800_0000;
      32:      taps = 32'h8020_0003;
      default: taps = '0;
    endcase
    return taps;
  endfunction

endpackage

// File: rtl/lfsr_advance.sv
// Combinational STEPS-fold Fibonacci shift-left LFSR advance.
// Each shift moves the state left and inserts the XOR of the tapped bits at bit 0.
module lfsr_advance #(
  parameter int unsigned      WIDTH = 16,
  parameter logic [WIDTH-1:0] TAPS  = '1,
  parameter int unsigned      STEPS = 1
) (
  input  logic [WIDTH-1:0] state_i,
  output logic [WIDTH-1:0] state_o
);

  logic [WIDTH-1:0] s;

  always_comb begin
    s = state_i;
    for (int unsigned i = 0; i < STEPS; i++) begin
      s = {s[WIDTH-2:0], ^(s & TAPS)};
    end
    state_o = s;
  end

endmodule

// File: rtl/lfsr_gen.sv
// Self-contained parametrised LFSR with seed loading, zero-seed fix-up and
// hardware period measurement against the most recently loaded seed.
module lfsr_gen
  import lfsr_pkg::*;
#(
  parameter int unsigned      WIDTH    = 16,
  parameter logic [WIDTH-1:0] TAPS     = WIDTH'(max_taps(WIDTH)),
  parameter int unsigned      STEPS    = 1,
  parameter logic [WIDTH-1:0] RST_SEED = WIDTH'(1)
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             load_i,
  input  logic [WIDTH-1:0] seed_i,
  input  logic             en_i,
  output logic [WIDTH-1:0] state_o,
  output logic             wrap_o,
  output logic [WIDTH-1:0] period_o,
  output logic             period_valid_o,
  output logic             zero_fix_o
);

  if (WIDTH < MIN_WIDTH || WIDTH > MAX_WIDTH) begin : g_bad_width
    $error("lfsr_gen: WIDTH %0d outside %0d..%0d", WIDTH, MIN_WIDTH, MAX_WIDTH);
  end
  if (STEPS < 1 || STEPS > WIDTH) begin : g_bad_steps
    $error("lfsr_gen: STEPS %0d outside 1..%0d", STEPS, WIDTH);
  end
  if (RST_SEED == '0) begin : g_bad_seed
    $error("lfsr_gen: RST_SEED must be non-zero");
  end
  if (TAPS == '0) begin : g_bad_taps
    $error("lfsr_gen: TAPS must be non-zero");
  end

  logic [WIDTH-1:0] state_q, state_d;
  logic [WIDTH-1:0] ref_q, ref_d;
  logic [WIDTH-1:0] cnt_q, cnt_d;
  logic [WIDTH-1:0] period_q, period_d;
  logic             valid_q, valid_d;
  logic             wrap_q, wrap_d;
  logic             zfix_q, zfix_d;

  logic [WIDTH-1:0] adv_state;
  logic [WIDTH-1:0] cnt_inc;
  logic [WIDTH-1:0] seed_fixed;
  logic             seed_zero;
  lfsr_act_e        action;

  lfsr_advance #(
    .WIDTH (WIDTH),
    .TAPS  (TAPS),
    .STEPS (STEPS)
  ) u_advance (
    .state_i (state_q),
    .state_o (adv_state)
  );

  // Load outranks enable; reset is handled in the register process.
  always_comb begin
    action = ActIdle;
    if (load_i) begin
      action = ActLoad;
    end else if (en_i) begin
      action = ActStep;
    end
  end

  always_comb begin
    seed_zero  = (seed_i == '0);
    seed_fixed = seed_zero ? WIDTH'(1) : seed_i;
    cnt_inc    = (&cnt_q) ? cnt_q : cnt_q + WIDTH'(1);
  end

  always_comb begin
    state_d  = state_q;
    ref_d    = ref_q;
    cnt_d    = cnt_q;
    period_d = period_q;
    valid_d  = valid_q;
    wrap_d   = 1'b0;
    zfix_d   = 1'b0;
    unique case (action)
      ActLoad: begin
        state_d  = seed_fixed;
        ref_d    = seed_fixed;
        cnt_d    = '0;
        period_d = '0;
        valid_d  = 1'b0;
        zfix_d   = seed_zero;
      end
      ActStep: begin
        state_d = adv_state;
        if (adv_state == ref_q) begin
          // Interval includes the enable that brought the state home.
          wrap_d   = 1'b1;
          period_d = cnt_inc;
          valid_d  = 1'b1;
          cnt_d    = '0;
        end else begin
          cnt_d = cnt_inc;
        end
      end
      default: ;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q  <= RST_SEED;
      ref_q    <= RST_SEED;
      cnt_q    <= '0;
      period_q <= '0;
      valid_q  <= 1'b0;
      wrap_q   <= 1'b0;
      zfix_q   <= 1'b0;
    end else begin
      state_q  <= state_d;
      ref_q    <= ref_d;
      cnt_q    <= cnt_d;
      period_q <= period_d;
      valid_q  <= valid_d;
      wrap_q   <= wrap_d;
      zfix_q   <= zfix_d;
    end
  end

  assign state_o        = state_q;
  assign wrap_o         = wrap_q;
  assign period_o       = period_q;
  assign period_valid_o = valid_q;
  assign zero_fix_o     = zfix_q;

endmodule

// File: tb/tb_lfsr_gen.sv
// Directed bench for lfsr_gen: four instances (16/1, 16/4, 4/1, 4/2) share clock
// and controls; expected values are hand-derived from the tap polynomials.
module tb_lfsr_gen;

  logic        clk = 1'b0;
  logic        reset = 1'b1;
  logic        load = 1'b0;
  logic        en = 1'b0;
  logic [15:0] seed16 = '0;
  logic [3:0]  seed4 = '0;

  logic [15:0] st_a, per_a, st_b, per_b;
  logic        w_a, v_a, z_a, w_b, v_b, z_b;
  logic [3:0]  st_c, per_c, st_d, per_d;
  logic        w_c, v_c, z_c, w_d, v_d, z_d;

  int n_pass = 0;
  int n_checks = 0;
  int early = 0;

  always #5 clk = ~clk;

  lfsr_gen #(.WIDTH(16), .STEPS(1)) u_a (
    .clk(clk), .reset(reset), .load_i(load), .seed_i(seed16), .en_i(en),
    .state_o(st_a), .wrap_o(w_a), .period_o(per_a), .period_valid_o(v_a), .zero_fix_o(z_a)
  );
  lfsr_gen #(.WIDTH(16), .STEPS(4)) u_b (
    .clk(clk), .reset(reset), .load_i(load), .seed_i(seed16), .en_i(en),
    .state_o(st_b), .wrap_o(w_b), .period_o(per_b), .period_valid_o(v_b), .zero_fix_o(z_b)
  );
  lfsr_gen #(.WIDTH(4), .STEPS(1)) u_c (
    .clk(clk), .reset(reset), .load_i(load), .seed_i(seed4), .en_i(en),
    .state_o(st_c), .wrap_o(w_c), .period_o(per_c), .period_valid_o(v_c), .zero_fix_o(z_c)
  );
  lfsr_gen #(.WIDTH(4), .STEPS(2)) u_d (
    .clk(clk), .reset(reset), .load_i(load), .seed_i(seed4), .en_i(en),
    .state_o(st_d), .wrap_o(w_d), .period_o(per_d), .period_valid_o(v_d), .zero_fix_o(z_d)
  );

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    assert (obs === exp) n_pass++;
    else $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
  endtask

  // Apply one cycle of controls, then sample 1 time unit after the edge.
  task automatic step(input logic l, input logic e);
    load = l;
    en   = e;
    @(posedge clk);
    #1;
    load = 1'b0;
    en   = 1'b0;
  endtask

  initial begin
    reset = 1'b1;
    @(posedge clk);
    @(posedge clk);
    #1;
    chk("rst_state16", st_a, 16'h0001);
    chk("rst_state4", st_c, 4'h1);
    chk("rst_flags16", {w_a, v_a, z_a}, 3'b000);
    chk("rst_period16", per_a, 16'h0000);
    reset = 1'b0;

    // Single enable after loading 1: STEPS=1 and STEPS=4 diverge.
    seed16 = 16'h0001;
    seed4  = 4'h1;
    step(1'b1, 1'b0);
    chk("load_state16", st_a, 16'h0001);
    chk("load_zfix16", z_a, 1'b0);
    step(1'b0, 1'b1);
    chk("s1_one_en", st_a, 16'h0002);
    chk("s4_one_en", st_b, 16'h0010);
    chk("w4s1_one_en", st_c, 4'h2);
    chk("w4s2_one_en", st_d, 4'h4);

    // Reload and run ten enables.
    step(1'b1, 1'b0);
    for (int i = 0; i < 10; i++) step(1'b0, 1'b1);
    chk("s1_ten_en", st_a, 16'h0400);
    chk("w4s1_ten_en", st_c, 4'h7);
    chk("w4s2_ten_en", st_d, 4'h6);
    step(1'b0, 1'b0);
    chk("idle_hold16", st_a, 16'h0400);
    chk("idle_nowrap4", w_c, 1'b0);
    step(1'b0, 1'b1);
    chk("s1_eleven_en", st_a, 16'h0801);
    chk("w4s1_eleven_en", st_c, 4'hF);
    chk("w4s2_eleven_en", st_d, 4'hA);

    for (int i = 12; i <= 14; i++) begin
      step(1'b0, 1'b1);
      if (w_a || v_a) early++;
    end
    chk("w4s1_pre_wrap", {w_c, v_c}, 2'b00);
    chk("w4s2_pre_wrap", {w_d, v_d}, 2'b00);
    step(1'b0, 1'b1);
    if (w_a || v_a) early++;
    chk("w4s1_wrap", {w_c, v_c}, 2'b11);
    chk("w4s1_period", per_c, 4'hF);
    chk("w4s1_wrap_state", st_c, 4'h1);
    chk("w4s2_wrap", {w_d, v_d}, 2'b11);
    chk("w4s2_period", per_d, 4'hF);
    step(1'b0, 1'b1);
    if (w_a || v_a) early++;
    chk("w4s1_wrap_pulse", {w_c, v_c}, 2'b01);

    for (int i = 17; i < 65535; i++) begin
      step(1'b0, 1'b1);
      if (w_a || v_a) early++;
    end
    chk("s1_no_early_wrap", early, 0);
    step(1'b0, 1'b1);
    chk("s1_full_wrap", {w_a, v_a}, 2'b11);
    chk("s1_full_period", per_a, 16'hFFFF);
    chk("s1_full_state", st_a, 16'h0001);
    step(1'b0, 1'b0);
    chk("s1_wrap_gone", {w_a, v_a}, 2'b01);
    chk("s1_period_held", per_a, 16'hFFFF);

    // Zero seed is replaced by 1 and clears the measurement.
    seed16 = 16'h0000;
    seed4  = 4'h0;
    step(1'b1, 1'b0);
    chk("zero_state16", st_a, 16'h0001);
    chk("zero_flags16", {z_a, v_a}, 2'b10);
    chk("zero_period16", per_a, 16'h0000);
    chk("zero_state4", {st_c, z_c}, {4'h1, 1'b1});
    step(1'b0, 1'b0);
    chk("zero_pulse_gone", z_a, 1'b0);

    // Mid-run reset with enable held.
    seed16 = 16'hACE1;
    step(1'b1, 1'b0);
    for (int i = 0; i < 100; i++) step(1'b0, 1'b1);
    reset = 1'b1;
    step(1'b0, 1'b1);
    reset = 1'b0;
    chk("midrst_state", st_a, 16'h0001);
    chk("midrst_flags", {w_a, v_a, z_a}, 3'b000);
    chk("midrst_period", per_a, 16'h0000);

    seed16 = 16'hBEEF;
    step(1'b1, 1'b1);
    chk("load_en_state", st_a, 16'hBEEF);

    // Load on what would be a wrapping enable: load wins.
    seed4 = 4'h1;
    step(1'b1, 1'b0);
    for (int i = 0; i < 15; i++) step(1'b0, 1'b1);
    chk("w4_valid_set", v_c, 1'b1);
    for (int i = 0; i < 14; i++) step(1'b0, 1'b1);
    chk("w4_at_C", st_c, 4'h8);
    seed4 = 4'h5;
    step(1'b1, 1'b1);
    chk("load_wins_state", st_c, 4'h5);
    chk("load_wins_flags", {w_c, v_c}, 2'b00);
    chk("load_wins_period", per_c, 4'h0);

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule

// File: doc/lfsr_gen.md
# lfsr_gen

Parametrised pseudo-random source that replaces the fixed 16-bit LFSR and its external state flop with a single self-contained block. It supports width 4–32, multi-bit advance per enable, runtime seed loading, and all-zero lock-up protection. It also measures its own period in hardware, so benches and downstream logic get a repeat flag and cycle count. It sits between the control FSM, which loads and enables it, and any consumer of random words.

## Interface
- WIDTH, 16, state width in bits; legal range 4..32
- TAPS, lfsr_pkg::max_taps(WIDTH), feedback tap mask; bit i set means state bit i feeds the XOR
- STEPS, 1, LFSR shifts applied per enabled cycle; legal range 1..WIDTH
- RST_SEED, 1, state after reset; must be non-zero
- clk  input  1  clock; all logic on rising edge
- reset  input  1  synchronous, active-high reset
- load_i  input  1  load seed_i on this edge
- seed_i  input  WIDTH  seed value sampled when load_i=1
- en_i  input  1  advance state by STEPS shifts
- state_o  output  WIDTH  current LFSR state (registered)
- wrap_o  output  1  one-cycle pulse: state_o has returned to the reference seed
- period_o  output  WIDTH  enables counted between the last two visits to the reference seed
- period_valid_o  output  1  period_o holds a measured value; sticky
- zero_fix_o  output  1  one-cycle pulse: a zero seed was replaced by 1

## Operation
- Single shift (Fibonacci, shift-left): next = {s[WIDTH-2:0], ^(s & TAPS)}. One enable applies this STEPS times combinationally.
- Reset values:
  - state_o = RST_SEED; ref = RST_SEED; cnt = 0
  - wrap_o = 0; period_o = 0; period_valid_o = 0; zero_fix_o = 0
- Priority order: reset > load_i > en_i.
- Load: state and ref take seed_i. If seed_i == 0, both take 1 and zero_fix_o pulses. Load also clears cnt, period_o and period_valid_o. en_i is ignored on a load cycle.
- Enable, no load:
  - state advances; cnt_next = cnt + 1, saturating at all-ones.
  - If the advanced state == ref: wrap_o = 1, period_o = cnt + 1, period_valid_o = 1, cnt = 0.
- Idle (no load, no en): state, cnt and ref hold; wrap_o = 0.
- Each new wrap overwrites period_o with the latest measured interval.
- The state can never become 0 from a non-zero value, because the taps are maximal-length and the zero seed is fixed on load.

## Timing
- All outputs are registered. state_o updates one cycle after load_i/en_i is sampled.
- wrap_o, period_o and zero_fix_o change on the same edge as the state_o update they describe.
- Back-to-back enables advance the state every cycle; there is no bubble.
- Reset mid-run takes effect on the next edge. No partial update occurs and no pending wrap pulse survives.
- Load on the same edge as a wrap-triggering enable: the load wins, so wrap_o = 0 and period_valid_o = 0.

## Structure
- Package lfsr_pkg holds:
  - max_taps(width) function: maximal-length tap table for 4..32 (e.g. 4 -> 4'hC, 16 -> 16'hB400)
  - MIN_WIDTH and MAX_WIDTH constants
- Sub-module lfsr_advance (combinational, parameters WIDTH/TAPS/STEPS) produces the STEPS-fold next state.
- Top lfsr_gen owns the state, ref and counter registers and the period/wrap logic.
- Elaboration-time assertions reject:
  - WIDTH or STEPS out of range
  - RST_SEED == 0
  - TAPS == 0

## Test plan
- WIDTH=16, STEPS=1: load 16'h0001, 10 enables -> state_o = 16'h0400; 11th enable -> 16'h0801.
- WIDTH=16: load 16'h0001, 65535 enables -> wrap_o pulses exactly once, on the 65535th, with period_o = 16'hFFFF and period_valid_o = 1. No wrap occurs earlier.
- WIDTH=4, STEPS=1: load 4'h1 -> sequence 1,2,4,9,3,… wraps after 15 enables, period_o = 15. WIDTH=4, STEPS=2 -> period_o = 15.
- WIDTH=16, STEPS=4: load 16'h0001, one enable -> state_o = 16'h0010.
- Load 16'h0000 -> state_o = 16'h0001, zero_fix_o pulses one cycle, period_valid_o = 0.
- Mid-run reset after 100 enables -> state_o = RST_SEED, all flags 0. Load+en on the same cycle -> state_o = seed_i, not advanced.
